// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: state codes, opcodes and
// datapath mux/ALU selections.
package multicycle_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECR    = 4'd6;
    localparam state_t S_EXECI    = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_BRANCH   = 4'd9;
    localparam state_t S_JAL      = 4'd10;
    localparam state_t S_JALR1    = 4'd11;
    localparam state_t S_JALR2    = 4'd12;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_imm_sel.sv
// Opcode to immediate-format decode; shared by the DECODE and MEMADR states.
module imm_sel
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] op_i,
    output logic [1:0] imm_src_o
);

    always_comb begin
        case (op_i)
            OP_BRANCH: imm_src_o = IMM_B;
            OP_JAL:    imm_src_o = IMM_J;
            OP_STORE:  imm_src_o = IMM_S;
            default:   imm_src_o = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style control unit: Moore/Mealy FSM whose only storage is
// the state register; all controls decode from state plus Instr/Zero/MemReady.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] Instr,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               MemReq,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               AdrSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         ALUOp,
    output logic               InstrDone,
    output logic               IllegalInstr
);

    state_t     state_q, state_d;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [1:0] imm_src;
    logic       unused_instr_bits;

    assign opcode            = Instr[6:0];
    assign funct3            = Instr[14:12];
    assign unused_instr_bits = ^{Instr[D_WIDTH-1:15], Instr[11:7]};

    imm_sel u_imm_sel (
        .op_i      (opcode),
        .imm_src_o (imm_src)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        MemReq       = 1'b0;
        PCWrite      = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        MemWrite     = 1'b0;
        AdrSrc       = 1'b0;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_RS2;
        ResultSrc    = RES_ALUOUT;
        ImmSrc       = IMM_I;
        ALUOp        = ALU_ADD;
        InstrDone    = 1'b0;
        IllegalInstr = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemReq = 1'b1;
                if (MemReady) begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURES;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = imm_src;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR1;
                    default: begin
                        IllegalInstr = 1'b1;
                        state_d      = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = imm_src;
                if (opcode == OP_LOAD)       state_d = S_MEMREAD;
                else if (opcode == OP_STORE) state_d = S_MEMWRITE;
                else                         state_d = S_FETCH;
            end
            S_MEMREAD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_RDATA;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                MemReq   = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (MemReady) begin
                    InstrDone = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUOp   = ALU_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                // funct3==001 (bne) inverts the sense of the zero flag
                ALUSrcA   = SRCA_RS1;
                ALUOp     = ALU_SUB;
                PCWrite   = Zero ^ (funct3 == 3'b001);
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL, S_JALR2: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_JALR1: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = S_JALR2;
            end
            default: state_d = S_FETCH;
        endcase
        // Reset may land mid-instruction; keep every side effect quiet while it is held.
        if (rst) begin
            MemReq       = 1'b0;
            PCWrite      = 1'b0;
            IRWrite      = 1'b0;
            RegWrite     = 1'b0;
            MemWrite     = 1'b0;
            InstrDone    = 1'b0;
            IllegalInstr = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl against a per-instruction step-list model.
module tb_multicycle_ctrl;

    typedef enum {K_FETCH, K_DEC, K_MADR, K_MRD, K_MWB, K_MWR, K_EXR, K_EXI,
                  K_AWB, K_BR, K_JAL, K_JR1, K_JR2} step_e;

    // {pcw,irw,rw,mw,adr,mreq,done,ill,asa,asb,rsrc,imm,aop}
    localparam logic [17:0] RMASK = 18'b11_1101_1100_0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] Instr = 32'd0;
    logic        Zero = 1'b0, MemReady = 1'b0;
    logic        MemReq, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUOp;
    logic        InstrDone, IllegalInstr;

    int    nvec = 0, nerr = 0;
    step_e q[$];

    multicycle_ctrl #(.D_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .Instr(Instr), .Zero(Zero),
        .MemReq(MemReq), .MemReady(MemReady),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .ALUOp(ALUOp),
        .InstrDone(InstrDone), .IllegalInstr(IllegalInstr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h instr=%h t=%0t", tag, got, exp, Instr, $time);
        end
    endtask

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        if (op == 7'b1100011)      return 2'b10;
        else if (op == 7'b1101111) return 2'b11;
        else if (op == 7'b0100011) return 2'b01;
        else                       return 2'b00;
    endfunction

    function automatic bit waits(input step_e k);
        return k == K_FETCH || k == K_MRD || k == K_MWR;
    endfunction

    // Control word each step must show, straight from the per-state output table.
    function automatic logic [17:0] expect_ctl(input step_e k, input logic [31:0] ins,
                                               input logic z, input logic mr);
        logic pcw = 0, irw = 0, rw = 0, mw = 0, adr = 0, mreq = 0, done = 0, ill = 0;
        logic [1:0] asa = 0, asb = 0, rsrc = 0, imm = 0, aop = 0;
        logic [6:0] op = ins[6:0];
        case (k)
            K_FETCH: begin
                mreq = 1;
                if (mr) begin irw = 1; pcw = 1; asb = 2'b10; rsrc = 2'b10; end
            end
            K_DEC: begin
                asa = 2'b01; asb = 2'b01; imm = imm_of(op);
                ill = !(op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                   7'b1100011, 7'b1101111, 7'b1100111});
            end
            K_MADR: begin asa = 2'b10; asb = 2'b01; imm = imm_of(op); end
            K_MRD:  begin mreq = 1; adr = 1; end
            K_MWB:  begin rsrc = 2'b01; rw = 1; done = 1; end
            K_MWR:  begin mreq = 1; mw = 1; adr = 1; done = mr; end
            K_EXR:  begin asa = 2'b10; aop = 2'b10; end
            K_EXI:  begin asa = 2'b10; asb = 2'b01; end
            K_AWB:  begin rw = 1; done = 1; end
            K_BR:   begin asa = 2'b10; aop = 2'b01; done = 1;
                          pcw = z ^ (ins[14:12] == 3'b001); end
            K_JAL, K_JR2: begin asa = 2'b01; asb = 2'b10; pcw = 1; end
            K_JR1:  begin asa = 2'b10; asb = 2'b01; end
            default: ;
        endcase
        return {pcw, irw, rw, mw, adr, mreq, done, ill, asa, asb, rsrc, imm, aop};
    endfunction

    task automatic load(input logic [31:0] ins);
        Instr = ins;
        q = '{K_FETCH, K_DEC};
        case (ins[6:0])
            7'b0000011: q = {q, K_MADR, K_MRD, K_MWB};
            7'b0100011: q = {q, K_MADR, K_MWR};
            7'b0110011: q = {q, K_EXR, K_AWB};
            7'b0010011: q = {q, K_EXI, K_AWB};
            7'b1100011: q = {q, K_BR};
            7'b1101111: q = {q, K_JAL, K_AWB};
            7'b1100111: q = {q, K_JR1, K_JR2, K_AWB};
            default: ;
        endcase
    endtask

    task automatic cyc(input logic r, input logic mr, input logic z);
        logic [17:0] act;
        step_e k;
        @(negedge clk);
        rst = r; MemReady = mr; Zero = z;
        #1;
        act = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, MemReq, InstrDone,
               IllegalInstr, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUOp};
        k = (q.size() != 0) ? q[0] : K_FETCH;
        if (r) chk("reset_quiet", act & RMASK, 18'd0);
        else   chk(k.name(), act, expect_ctl(k, Instr, z, mr));
        @(posedge clk);
        if (r) q.delete();
        else if (q.size() != 0 && (!waits(k) || mr)) void'(q.pop_front());
        #1;
    endtask

    // Directed instruction run: 'w' wait cycles in data-memory steps, fetch always ready.
    task automatic run_instr(input logic [31:0] ins, input logic z, input int w);
        int left = w;
        logic mr;
        load(ins);
        while (q.size() != 0) begin
            mr = 1'b1;
            if ((q[0] == K_MRD || q[0] == K_MWR) && left > 0) begin
                mr = 1'b0;
                left--;
            end
            cyc(1'b0, mr, z);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0000000, 7'b0};
        logic [31:0] ins = $urandom;
        int idx = $urandom_range(0, 8);
        ins[6:0] = (idx == 8) ? 7'($urandom) : ops[idx];
        ins[14:12] = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'($urandom);
        return ins;
    endfunction

    initial begin
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        run_instr(32'h002081b3, 1'b0, 0);              // add x3,x1,x2
        run_instr(32'h0000a183, 1'b0, 3);              // lw, 3 wait cycles
        run_instr(32'h00208063, 1'b1, 0);              // beq, Zero=1
        run_instr(32'h00209063, 1'b1, 0);              // bne, Zero=1
        run_instr(32'h000080e7, 1'b0, 0);              // jalr
        run_instr(32'h004000ef, 1'b0, 0);              // jal
        run_instr(32'h00000000, 1'b0, 0);              // illegal
        run_instr(32'h00500093, 1'b0, 1);              // addi
        load(32'h0020a223);                            // sw, reset during wait
        while (q.size() != 0 && q[0] != K_MWR) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        run_instr(32'h002081b3, 1'b0, 0);
        for (int i = 0; i < 3000; i++) begin
            if (q.size() == 0) load(rand_instr());
            cyc($urandom_range(0, 99) < 3, 1'($urandom), 1'($urandom));
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32, instruction width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports Instr (input, D_WIDTH, registered instruction) and Zero (input, 1, ALU zero flag).
REQ-005 SHALL have ports MemReq (output, 1, memory access request) and MemReady (input, 1, access completes this cycle).
REQ-006 SHALL have outputs PCWrite, IRWrite, RegWrite, MemWrite and AdrSrc, each 1 bit; AdrSrc 0=PC, 1=ALUOut.
REQ-007 SHALL have outputs ALUSrcA, ALUSrcB, ResultSrc, ImmSrc and ALUOp, each 2 bits.
REQ-008 SHALL encode ALUSrcA 00=PC, 01=OldPC, 10=rs1; ALUSrcB 00=rs2, 01=imm, 10=const 4; ResultSrc 00=ALUOut, 01=ReadData, 10=ALUResult.
REQ-009 SHALL have outputs InstrDone (1, one-cycle retire pulse) and IllegalInstr (1, one-cycle pulse).

Function
REQ-010 SHALL implement FSM states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR1, JALR2.
REQ-011 Outputs not listed for a state SHALL be 0.
REQ-012 FETCH SHALL assert MemReq with AdrSrc=0 and hold until MemReady=1, staying in FETCH with IRWrite/PCWrite low while MemReady=0.
REQ-013 In FETCH with MemReady=1, the FSM SHALL assert IRWrite and PCWrite with ALUSrcA=00, ALUSrcB=10, ALUOp=00 and ResultSrc=10, then go to DECODE.
REQ-014 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ALUOp=00 and ImmSrc per opcode (B=10, J=11, S=01, else 00).
REQ-015 DECODE SHALL branch on opcode: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BRANCH, 1101111 -> JAL, 1100111 -> JALR1.
REQ-016 From DECODE, any other opcode SHALL pulse IllegalInstr and go to FETCH.
REQ-017 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00 and ImmSrc per opcode, then go to MEMREAD for opcode 0000011 or MEMWRITE for 0100011.
REQ-018 MEMREAD SHALL assert MemReq with AdrSrc=1 and wait for MemReady, then go to MEMWB.
REQ-019 MEMWB SHALL drive ResultSrc=01 and RegWrite=1, pulse InstrDone, and go to FETCH.
REQ-020 MEMWRITE SHALL assert MemReq, MemWrite and AdrSrc=1 while waiting for MemReady; on MemReady it SHALL pulse InstrDone and go to FETCH.
REQ-021 EXECR SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=10, then go to ALUWB.
REQ-022 EXECI SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00, then go to ALUWB.
REQ-023 ALUWB SHALL drive ResultSrc=00 and RegWrite=1, pulse InstrDone, and go to FETCH.
REQ-024 BRANCH SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, with PCWrite = Zero XOR (funct3==001).
REQ-025 BRANCH SHALL pulse InstrDone and go to FETCH.
REQ-026 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00 and PCWrite=1, then go to ALUWB.
REQ-027 JALR1 SHALL drive ALUSrcA=10, ALUSrcB=01, ImmSrc=00, ALUOp=00, then go to JALR2.
REQ-028 JALR2 SHALL match JAL outputs, then go to ALUWB.
REQ-029 Outputs SHALL be combinational from the registered state plus Instr, Zero and MemReady; the state register SHALL be the only storage.
REQ-030 MemReq SHALL stay asserted, with stable AdrSrc/MemWrite, from the first wait cycle until the MemReady cycle inclusive.

Reset
REQ-031 rst=1 at a clock edge SHALL force state FETCH, including mid-instruction and mid-memory-wait.
REQ-032 While rst=1, all write enables, MemReq, InstrDone and IllegalInstr SHALL be 0.
REQ-033 On the first cycle after reset deasserts, the FSM SHALL be in FETCH with MemReq=1.

Structure
REQ-034 A shared package SHALL hold the state enum, opcode constants and the ALUSrcA/ALUSrcB/ResultSrc/ImmSrc/ALUOp encodings.
REQ-035 Sub-module imm_sel SHALL map opcode to ImmSrc and be reused by DECODE and MEMADR.

Verification
REQ-036 Reset, then add x3,x1,x2 with MemReady=1 -> states FETCH,DECODE,EXECR,ALUWB; RegWrite high only in ALUWB; one InstrDone.
REQ-037 lw with MemReady low for 3 cycles in MEMREAD -> MemReq and AdrSrc=1 held 4 cycles; MEMWB 1 cycle later with ResultSrc=01.
REQ-038 beq with Zero=1 -> PCWrite=1 in BRANCH; bne (funct3=001) with Zero=1 -> PCWrite=0.
REQ-039 jalr -> sequence JALR1, JALR2 (PCWrite=1), ALUWB (RegWrite=1); total 5 cycles with MemReady=1.
REQ-040 Opcode 0000000 -> IllegalInstr pulse in DECODE, no write enables, next state FETCH.
REQ-041 rst asserted during MEMWRITE wait -> MemWrite drops next cycle; state FETCH; no InstrDone.
